rom_upload_ctrl: RTL and testbench

//  Read-back side of the ROM download path. It serves data_io upload requests (NVRAM/hiscore/ROM

---
 rtl/rom_upload_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_rom_upload_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_upload_ctrl.sv
// rom_upload_ctrl: serves data_io upload reads by fetching 16-bit words from
// SDRAM over a toggle req/ack port, with a one-word cache and a 1-deep
// pending slot for requests that arrive while a fetch is outstanding.
module rom_upload_ctrl #(
  parameter int unsigned AW      = 23,
  parameter logic [24:0] BASE    = 25'h10000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          din_valid,
  output logic          busy,
  output logic          err,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic          port_we,
  input  logic [15:0]   port_q
);

  localparam int unsigned IAW = 25;
  localparam int unsigned TW  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            port_req_q, port_req_d;
  logic [AW-1:0]   port_a_q, port_a_d;
  logic [1:0]      port_ds_q, port_ds_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sel_q, sel_d;
  logic [7:0]      res_q, res_d;
  logic [15:0]     cache_q, cache_d;
  logic [AW-1:0]   cache_word_q, cache_word_d;
  logic            cache_vld_q, cache_vld_d;
  logic            pend_vld_q, pend_vld_d;
  logic [IAW-1:0]  pend_addr_q, pend_addr_d;
  logic            abort_q, abort_d;
  logic [7:0]      din_q, din_d;
  logic            din_valid_q, din_valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            upload_q;

  logic            upload_rise;
  logic            rd_ok;
  logic            src_go;
  logic [IAW-1:0]  src_addr;
  logic [IAW-1:0]  src_off;
  logic [AW-1:0]   src_word;
  logic            src_oor;
  logic            src_hit;
  logic            ack_match;
  logic            timed_out;

  // Request source decode: a pending request is always served before a new one
  always_comb begin
    upload_rise = ioctl_upload & ~upload_q;
    rd_ok       = ioctl_rd & ioctl_upload;
    src_addr    = pend_vld_q ? pend_addr_q : ioctl_addr;
    src_go      = ioctl_upload & (pend_vld_q | ioctl_rd);
    src_off     = src_addr - BASE;
    src_word    = AW'(src_off >> 1);
    src_oor     = (src_addr < BASE);
    src_hit     = cache_vld_q & ~upload_rise & (src_word == cache_word_q);
    ack_match   = (port_ack == port_req_q);
    timed_out   = (timer_q == TW'(TIMEOUT));
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    port_req_d   = port_req_q;
    port_a_d     = port_a_q;
    port_ds_d    = port_ds_q;
    timer_d      = timer_q;
    sel_d        = sel_q;
    res_d        = res_q;
    cache_d      = cache_q;
    cache_word_d = cache_word_q;
    cache_vld_d  = cache_vld_q;
    pend_vld_d   = pend_vld_q;
    pend_addr_d  = pend_addr_q;
    abort_d      = abort_q;
    din_d        = din_q;
    din_valid_d  = 1'b0;
    err_d        = err_q;

    if (upload_rise) begin
      cache_vld_d = 1'b0;
      err_d       = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        // Follow the ack line so a stray late ack never looks like a request
        port_req_d = port_ack;
        if (src_go) begin
          pend_vld_d = 1'b0;
          if (src_oor) begin
            din_d       = 8'hFF;
            din_valid_d = 1'b1;
          end else if (src_hit) begin
            din_d       = src_off[0] ? cache_q[15:8] : cache_q[7:0];
            din_valid_d = 1'b1;
          end else begin
            port_a_d   = src_word;
            port_ds_d  = {src_off[0], ~src_off[0]};
            sel_d      = src_off[0];
            port_req_d = ~port_ack;
            timer_d    = '0;
            abort_d    = 1'b0;
            state_d    = S_REQ;
          end
          // The slot frees up this cycle, so a fresh strobe refills it
          if (pend_vld_q && rd_ok) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = ioctl_addr;
          end
        end
      end
      S_REQ, S_WAIT: begin
        state_d = S_WAIT;
        if (!ioctl_upload) abort_d = 1'b1;
        if (ack_match) begin
          if (abort_q || !ioctl_upload) begin
            cache_vld_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            cache_d      = port_q;
            cache_word_d = port_a_q;
            cache_vld_d  = 1'b1;
            res_d        = sel_q ? port_q[15:8] : port_q[7:0];
            state_d      = S_DONE;
          end
        end else if (timed_out) begin
          cache_vld_d = 1'b0;
          if (abort_q || !ioctl_upload) begin
            state_d = S_IDLE;
          end else begin
            res_d   = 8'hFF;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (ioctl_upload) begin
          din_d       = res_q;
          din_valid_d = 1'b1;
        end else begin
          cache_vld_d = 1'b0;
        end
      end
    endcase

    // Requests arriving mid-fetch go to the single pending slot or are dropped
    if ((state_q != S_IDLE) && rd_ok) begin
      if (pend_vld_q) begin
        err_d = 1'b1;
      end else begin
        pend_vld_d  = 1'b1;
        pend_addr_d = ioctl_addr;
      end
    end

    if (!ioctl_upload) pend_vld_d = 1'b0;

    busy_d = (state_d != S_IDLE) | pend_vld_d;
  end

  // State and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      port_req_q   <= port_ack;
      port_a_q     <= '0;
      port_ds_q    <= '0;
      timer_q      <= '0;
      sel_q        <= 1'b0;
      res_q        <= '0;
      cache_q      <= '0;
      cache_word_q <= '0;
      cache_vld_q  <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      abort_q      <= 1'b0;
      din_q        <= '0;
      din_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      upload_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_req_q   <= port_req_d;
      port_a_q     <= port_a_d;
      port_ds_q    <= port_ds_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      res_q        <= res_d;
      cache_q      <= cache_d;
      cache_word_q <= cache_word_d;
      cache_vld_q  <= cache_vld_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      abort_q      <= abort_d;
      din_q        <= din_d;
      din_valid_q  <= din_valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      upload_q     <= ioctl_upload;
    end
  end

  assign ioctl_din = din_q;
  assign din_valid = din_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign port_req  = port_req_q;
  assign port_a    = port_a_q;
  assign port_ds   = port_ds_q;
  assign port_we   = 1'b0;

endmodule

// File: tb/tb_rom_upload_ctrl.sv
// Bench for rom_upload_ctrl: SDRAM toggle-port model, byte-level reference
// model of the address map and cache, scenario tasks run in sequence.
module tb_rom_upload_ctrl;

  localparam int unsigned AW   = 23;
  localparam logic [24:0] BASE = 25'h10000;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          din_valid;
  logic          busy;
  logic          err;
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_q;

  rom_upload_ctrl #(.AW(AW), .BASE(BASE), .TIMEOUT(255)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .din_valid    (din_valid),
    .busy         (busy),
    .err          (err),
    .port_req     (port_req),
    .port_ack     (port_ack),
    .port_a       (port_a),
    .port_ds      (port_ds),
    .port_we      (port_we),
    .port_q       (port_q)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          req_toggles = 0;
  int          last_tog_cyc = -1;
  logic        last_req;
  logic [7:0]  vdata [$];
  int          vcyc [$];
  bit          model_en = 1'b0;
  int          mdelay = 5;
  int          mcnt = 0;
  int          ack_cyc = -1;
  bit          cvalid = 1'b0;
  int unsigned cword = 0;

  // Expected byte from the address map and the SDRAM contents
  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    int unsigned off;
    logic [15:0] w;
    if (a < BASE) return 8'hFF;
    off = 32'(a - BASE);
    w = mem[8'(off / 2)];
    return (off % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  function automatic bit exp_miss(input logic [24:0] a);
    if (a < BASE) return 1'b0;
    return !(cvalid && cword == 32'(a - BASE) / 2);
  endfunction

  // Advance one clock, record DUT events, and run the SDRAM model
  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (port_req !== last_req) begin
      req_toggles++;
      last_tog_cyc = cyc;
      last_req = port_req;
    end
    if (din_valid === 1'b1) begin
      vdata.push_back(ioctl_din);
      vcyc.push_back(cyc);
    end
    if (model_en && port_req !== port_ack) begin
      mcnt++;
      if (mcnt >= mdelay) begin
        port_q   = mem[port_a[7:0]];
        port_ack = port_req;
        ack_cyc  = cyc;
        mcnt     = 0;
      end
    end else begin
      mcnt = 0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_rd(input logic [24:0] a, output int rd_cyc);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    step();
    ioctl_rd = 1'b0;
    rd_cyc   = cyc;
  endtask

  task automatic upload_restart();
    ioctl_upload = 1'b0;
    step();
    ioctl_upload = 1'b1;
    step();
    cvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    port_ack = 1'b1;
    port_q = '0;
    steps(3);
    checks++; if (ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h exp 00", ioctl_din); end
    checks++; if (din_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", din_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (port_a !== '0 || port_ds !== 2'b00) begin errors++; $display("FAIL reset_port got a=%h ds=%b exp 0/00", port_a, port_ds); end
    checks++; if (port_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", port_we); end
    checks++; if (port_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1 (=ack)", port_req); end
    last_req = port_req;
    reset = 1'b0;
    step();
  endtask

  task automatic test_miss();
    int rd_cyc;
    int t0;
    int v0;
    upload_restart();
    model_en = 1'b1;
    mdelay = 5;
    t0 = req_toggles;
    v0 = vdata.size();
    do_rd(25'h10004, rd_cyc);
    checks++; if (req_toggles != t0 + 1 || last_tog_cyc != rd_cyc) begin errors++; $display("FAIL miss_req_toggle got toggles=%0d at %0d exp 1 at %0d", req_toggles - t0, last_tog_cyc, rd_cyc); end
    checks++; if (port_a !== 23'd2 || port_ds !== 2'b01) begin errors++; $display("FAIL miss_port got a=%0d ds=%b exp 2/01", port_a, port_ds); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL miss_busy got %b exp 1", busy); end
    steps(12);
    checks++; if (vdata.size() != v0 + 1) begin errors++; $display("FAIL miss_count got %0d exp 1", vdata.size() - v0); end
    else begin
      checks++; if (vdata[v0] !== 8'hEF) begin errors++; $display("FAIL miss_data got %h exp EF", vdata[v0]); end
      checks++; if (vcyc[v0] != ack_cyc + 2) begin errors++; $display("FAIL miss_latency got cyc %0d exp %0d", vcyc[v0], ack_cyc + 2); end
    end
    cvalid = 1'b1;
    cword = 2;
  endtask

  task automatic test_hit_and_range();
    int rd_cyc;
    int t0;
    int v0;
    t0 = req_toggles;
    v0 = vdata.size();
    do_rd(25'h10005, rd_cyc);
    steps(3);
    checks++; if (req_toggles != t0) begin errors++; $display("FAIL hit_no_req got %0d toggles exp 0", req_toggles - t0); end
    checks++; if (vdata.size() != v0 + 1 || vdata[v0] !== 8'hBE || vcyc[v0] != rd_cyc) begin errors++; $display("FAIL hit_data got n=%0d exp n=1 data BE at %0d", vdata.size() - v0, rd_cyc); end
    v0 = vdata.size();
    do_rd(25'h0FFFF, rd_cyc);
    steps(3);
    checks++; if (req_toggles != t0) begin errors++; $display("FAIL range_no_req got %0d toggles exp 0", req_toggles - t0); end
    checks++; if (vdata.size() != v0 + 1 || vdata[v0] !== 8'hFF || vcyc[v0] != rd_cyc) begin errors++; $display("FAIL range_data got n=%0d exp n=1 data FF at %0d", vdata.size() - v0, rd_cyc); end
  endtask

  task automatic test_random();
    int rd_cyc;
    int t0;
    int v0;
    logic [24:0] a;
    bit miss;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) a = 25'($urandom_range(0, 32'hFFFF));
      else a = BASE + 25'($urandom_range(0, 63));
      mdelay = int'($urandom_range(1, 8));
      miss = exp_miss(a);
      t0 = req_toggles;
      v0 = vdata.size();
      do_rd(a, rd_cyc);
      steps(15);
      checks++;
      if (req_toggles != t0 + (miss ? 1 : 0) || vdata.size() != v0 + 1 || vdata[v0] !== exp_byte(a)) begin
        errors++;
        $display("FAIL rand_rd addr=%h got toggles=%0d n=%0d data=%h exp toggles=%0d n=1 data=%h",
                 a, req_toggles - t0, vdata.size() - v0, (vdata.size() > v0) ? vdata[v0] : 8'hxx,
                 miss ? 1 : 0, exp_byte(a));
      end
      if (miss) begin
        cvalid = 1'b1;
        cword = 32'(a - BASE) / 2;
      end
    end
  endtask

  task automatic test_timeout();
    int rd_cyc;
    int v0;
    int k;
    model_en = 1'b0;
    upload_restart();
    v0 = vdata.size();
    do_rd(25'h10040, rd_cyc);
    k = 0;
    while (vdata.size() == v0 && k < 300) begin
      step();
      k++;
    end
    checks++;
    if (vdata.size() == v0) begin
      errors++; $display("FAIL timeout_valid got none exp pulse within 300 cycles");
    end else begin
      checks++; if (vdata[v0] !== 8'hFF) begin errors++; $display("FAIL timeout_data got %h exp FF", vdata[v0]); end
      checks++; if (vcyc[v0] - rd_cyc < 250 || vcyc[v0] - rd_cyc > 265) begin errors++; $display("FAIL timeout_latency got %0d exp 250..265", vcyc[v0] - rd_cyc); end
    end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", err); end
    steps(3);
    mcnt = 0;
    model_en = 1'b1;
    upload_restart();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    int rd_cyc;
    int t0;
    int v0;
    int k;
    upload_restart();
    mdelay = 4;
    t0 = req_toggles;
    v0 = vdata.size();
    do_rd(25'h10010, rd_cyc);
    do_rd(25'h10020, rd_cyc);
    do_rd(25'h10030, rd_cyc);
    k = 0;
    while (busy === 1'b1 && k < 80) begin
      step();
      k++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0 within 80 cycles", busy); end
    steps(3);
    checks++;
    if (vdata.size() != v0 + 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", vdata.size() - v0);
    end else if (vdata[v0] !== exp_byte(25'h10010) || vdata[v0 + 1] !== exp_byte(25'h10020)) begin
      errors++; $display("FAIL b2b_order got %h %h exp %h %h", vdata[v0], vdata[v0 + 1], exp_byte(25'h10010), exp_byte(25'h10020));
    end
    checks++; if (req_toggles != t0 + 2) begin errors++; $display("FAIL b2b_toggles got %0d exp 2", req_toggles - t0); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_err got %b exp 1", err); end
    upload_restart();
  endtask

  task automatic test_abort();
    int rd_cyc;
    int t0;
    int v0;
    model_en = 1'b0;
    v0 = vdata.size();
    do_rd(25'h10050, rd_cyc);
    steps(3);
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || port_req !== port_ack) begin errors++; $display("FAIL rst_wait got busy=%b req=%b ack=%b exp busy=0 req=ack", busy, port_req, port_ack); end
    reset = 1'b0;
    cvalid = 1'b0;
    step();
    port_ack = ~port_ack;
    steps(10);
    checks++; if (vdata.size() != v0 || busy !== 1'b0 || port_req !== port_ack) begin errors++; $display("FAIL late_ack got n=%0d busy=%b req=%b ack=%b exp n=0 busy=0 req=ack", vdata.size() - v0, busy, port_req, port_ack); end
    do_rd(25'h10060, rd_cyc);
    steps(3);
    ioctl_upload = 1'b0;
    steps(2);
    port_q = 16'h1234;
    port_ack = port_req;
    steps(10);
    checks++; if (vdata.size() != v0 || busy !== 1'b0 || port_req !== port_ack) begin errors++; $display("FAIL upload_drop got n=%0d busy=%b req=%b ack=%b exp n=0 busy=0 req=ack", vdata.size() - v0, busy, port_req, port_ack); end
    ioctl_upload = 1'b1;
    step();
    cvalid = 1'b0;
    model_en = 1'b1;
    mdelay = 3;
    t0 = req_toggles;
    do_rd(25'h10060, rd_cyc);
    steps(12);
    checks++; if (req_toggles != t0 + 1 || vdata.size() != v0 + 1 || vdata[v0] !== exp_byte(25'h10060)) begin errors++; $display("FAIL post_abort_rd got toggles=%0d n=%0d exp toggles=1 n=1 data=%h", req_toggles - t0, vdata.size() - v0, exp_byte(25'h10060)); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[2] = 16'hBEEF;
    test_reset();
    test_miss();
    test_hit_and_range();
    test_random();
    test_timeout();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
